// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cores.
// The serial adder and subtractor use the same state encoding and default width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_core_if.sv
// Operand and result handshake bundle for the serial subtractor.
// The master side supplies the operands and consumes the result.
interface serial_subtractor_core_if
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             ser_bit;
    logic             ser_vld;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero, ser_bit, ser_vld
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero, ser_bit, ser_vld
    );

endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out to the next bit.
module full_subtractor_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor_core.sv
// Bit-serial A-B, LSB first, through a single full-subtractor cell.
// Operands arrive on one handshake; the difference, borrow and zero flag leave on another.
module serial_subtractor_core
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_subtractor_core_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             borrowReg_q, borrowReg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrowOut_q, borrowOut_d;
    logic             zero_q, zero_d;

    logic             cellD;
    logic             cellBout;
    logic [WIDTH-1:0] resultShifted;

    full_subtractor_cell uCell (
        .a_i   (aShift_q[0]),
        .b_i   (bShift_q[0]),
        .bin_i (borrowReg_q),
        .d_o   (cellD),
        .bout_o(cellBout)
    );

    // Each new difference bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign resultShifted = {cellD, result_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        aShift_d    = aShift_q;
        bShift_d    = bShift_q;
        result_d    = result_q;
        borrowReg_d = borrowReg_q;
        count_d     = count_q;
        diff_d      = diff_q;
        borrowOut_d = borrowOut_q;
        zero_d      = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    aShift_d    = bus.a;
                    bShift_d    = bus.b;
                    borrowReg_d = 1'b0;
                    count_d     = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                aShift_d    = aShift_q >> 1;
                bShift_d    = bShift_q >> 1;
                result_d    = resultShifted;
                borrowReg_d = cellBout;
                count_d     = count_q + CNT_W'(1);
                if (count_q == LAST_BIT) begin
                    diff_d      = resultShifted;
                    borrowOut_d = cellBout;
                    zero_d      = (resultShifted == '0);
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            aShift_q    <= '0;
            bShift_q    <= '0;
            result_q    <= '0;
            borrowReg_q <= 1'b0;
            count_q     <= '0;
            diff_q      <= '0;
            borrowOut_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            aShift_q    <= aShift_d;
            bShift_q    <= bShift_d;
            result_q    <= result_d;
            borrowReg_q <= borrowReg_d;
            count_q     <= count_d;
            diff_q      <= diff_d;
            borrowOut_q <= borrowOut_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrowOut_q;
    assign bus.zero      = zero_q;
    assign bus.ser_vld   = (state_q == S_BUSY);
    assign bus.ser_bit   = (state_q == S_BUSY) & cellD;

endmodule

// File: tb/tb_serial_subtractor_core.sv
// Self-checking bench for serial_subtractor_core: directed corner cases plus
// randomized operations with handshake gaps, checked against plain arithmetic.
module tb_serial_subtractor_core;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;

    int unsigned testCount = 0;
    int unsigned failCount = 0;

    serial_subtractor_core_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor_core #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits for the core to be ready, then presents the operands for exactly one accepting edge.
    task automatic acceptOp(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB, output bit ok);
        int waitCycles;
        waitCycles = 0;
        ok = 1'b0;
        @(negedge clk);
        while (!bus.in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            return;
        end
        bus.a        = opA;
        bus.b        = opB;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ok = 1'b1;
    endtask

    // Called just after the accepting edge; follows the operation to DONE and releases it.
    task automatic collectResult(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input int readyDelay, input bit noise,
                                 input bit holdNext, input logic [WIDTH-1:0] nextA,
                                 input logic [WIDTH-1:0] nextB);
        int               fullA;
        int               fullB;
        logic [WIDTH-1:0] expDiff;
        logic             expBorrow;
        logic             expZero;
        logic [WIDTH-1:0] serialSeen;
        int               vldCount;
        int               latency;
        int               stallBad;
        fullA      = int'(opA);
        fullB      = int'(opB);
        expDiff    = WIDTH'((fullA - fullB + (1 << WIDTH)) % (1 << WIDTH));
        expBorrow  = (fullA < fullB);
        expZero    = (fullA == fullB);
        serialSeen = '0;
        vldCount   = 0;
        latency    = -1;
        stallBad   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                latency = c;
                break;
            end
            if (c < WIDTH) serialSeen[c] = bus.ser_bit;
            if (bus.ser_vld) vldCount++;
            if (noise) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.a         = WIDTH'($urandom);
                bus.b         = WIDTH'($urandom);
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = holdNext;
        if (holdNext) begin
            bus.a = nextA;
            bus.b = nextB;
        end
        checkOutput("latency", latency, WIDTH);
        if (latency < 0) return;
        checkOutput("ser_vld_cycles", vldCount, WIDTH);
        checkOutput("ser_bits", serialSeen, expDiff);
        for (int s = 0; s < readyDelay; s++) begin
            @(negedge clk);
            if (bus.in_ready || !bus.out_valid || bus.diff !== expDiff ||
                bus.borrow !== expBorrow || bus.zero !== expZero) stallBad++;
        end
        if (readyDelay > 0) checkOutput("stall_stable", stallBad, 0);
        checkOutput("diff", bus.diff, expDiff);
        checkOutput("borrow", bus.borrow, expBorrow);
        checkOutput("zero", bus.zero, expZero);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input int readyDelay, input bit noise);
        bit ok;
        acceptOp(opA, opB, ok);
        if (ok) collectResult(opA, opB, readyDelay, noise, 1'b0, '0, '0);
    endtask

    initial begin
        bit               ok;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst           = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_flags", {bus.in_ready, bus.out_valid, bus.borrow, bus.zero, bus.ser_bit, bus.ser_vld}, 6'b100000);
        checkOutput("reset_diff", bus.diff, 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'h5A, 8'h23, 0, 1'b0);
        applyStimulus(8'h10, 8'h20, 1, 1'b0);
        applyStimulus(8'h33, 8'h33, 0, 1'b0);
        applyStimulus(8'h00, 8'hFF, 2, 1'b0);
        applyStimulus(8'hFF, 8'h00, 0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 0, 1'b0);

        // Long stall in DONE with the next operands already offered.
        acceptOp(8'hA5, 8'h5A, ok);
        if (ok) begin
            collectResult(8'hA5, 8'h5A, 20, 1'b0, 1'b1, 8'h44, 8'h11);
            @(negedge clk);
            checkOutput("no_same_cycle_accept", {bus.in_ready, bus.ser_vld, bus.out_valid}, 3'b100);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            collectResult(8'h44, 8'h11, 0, 1'b0, 1'b0, '0, '0);
        end

        // Reset while bit 4 is on the serial output.
        acceptOp(8'h5A, 8'h23, ok);
        if (ok) begin
            repeat (5) @(negedge clk);
            checkOutput("pre_reset_busy", {bus.ser_vld, bus.ser_bit}, 2'b11);
            #1;
            rst = 1'b1;
            #1;
            checkOutput("async_reset_flags", {bus.in_ready, bus.out_valid, bus.borrow, bus.zero, bus.ser_bit, bus.ser_vld}, 6'b100000);
            checkOutput("async_reset_diff", bus.diff, 0);
            @(negedge clk);
            rst = 1'b0;
        end
        applyStimulus(8'h01, 8'h01, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
